// File: rtl/cell_link_tx_framer.sv
// cell_link_tx_framer
//   Frames upstream payload words into a transceiver word stream. Each packet
//   is sent as SOP, the payload words, then an EOP word that carries a
//   CRC-16-CCITT over the payload. FILL words cover short upstream gaps. A
//   packet is aborted when a gap runs too long or the packet exceeds
//   MAX_WORDS; the rest of an aborted packet is drained up to its tlast.
// Ports
//   aclk, areset      : clock, synchronous active-high reset
//   enable            : allows a new packet to start (ignored mid-packet)
//   s_tvalid/s_tready : upstream handshake; s_tdata payload, s_tlast end
//   tx_data/charisk   : registered transceiver word and per-byte K flags
//   pkt_count         : packets closed with EOP (wraps)
//   abort_count       : ABORT words emitted (saturates)
module cell_link_tx_framer #(
  parameter int unsigned MAX_WORDS   = 256,
  parameter int unsigned GAP_TIMEOUT = 16
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        enable,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic [31:0] s_tdata,
  input  logic        s_tlast,
  output logic [31:0] tx_data,
  output logic [3:0]  tx_charisk,
  output logic [15:0] pkt_count,
  output logic [7:0]  abort_count
);

  localparam logic [31:0] W_IDLE  = 32'h505050BC;
  localparam logic [31:0] W_SOP   = 32'h000000FB;
  localparam logic [31:0] W_FILL  = 32'h0000001C;
  localparam logic [31:0] W_ABORT = 32'h000000FE;
  localparam logic [15:0] MAXW    = 16'(MAX_WORDS);
  localparam logic [8:0]  GAPW    = 9'(GAP_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_EOP,
    ST_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [7:0]  gap_q, gap_d;
  logic [31:0] txd_q, txd_d;
  logic [3:0]  txk_q, txk_d;
  logic [15:0] pkt_q, pkt_d;
  logic [7:0]  abort_q, abort_d;
  logic        ready;
  logic [8:0]  gap_inc;

  // Bit-serial CRC-16-CCITT over one 32-bit word, MSB first.
  function automatic logic [15:0] crc_next(input logic [15:0] c, input logic [31:0] d);
    logic [15:0] r;
    r = c;
    for (int unsigned i = 0; i < 32; i++) begin
      if (r[15] ^ d[31 - i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else                   r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  assign gap_inc = {1'b0, gap_q} + 9'd1;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    wcnt_d  = wcnt_q;
    gap_d   = gap_q;
    txd_d   = W_IDLE;
    txk_d   = 4'b0001;
    pkt_d   = pkt_q;
    abort_d = abort_q;
    ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_tvalid && enable) begin
          txd_d   = W_SOP;
          crc_d   = 16'hFFFF;
          wcnt_d  = '0;
          gap_d   = '0;
          state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (wcnt_q == MAXW) begin
          txd_d   = W_ABORT;
          abort_d = (abort_q == 8'hFF) ? abort_q : abort_q + 8'd1;
          state_d = ST_DRAIN;
        end else begin
          ready = 1'b1;
          if (s_tvalid) begin
            txd_d  = s_tdata;
            txk_d  = 4'b0000;
            crc_d  = crc_next(crc_q, s_tdata);
            wcnt_d = wcnt_q + 16'd1;
            gap_d  = '0;
            if (s_tlast) state_d = ST_EOP;
          end else if (gap_inc == GAPW) begin
            txd_d   = W_ABORT;
            abort_d = (abort_q == 8'hFF) ? abort_q : abort_q + 8'd1;
            state_d = ST_DRAIN;
          end else begin
            txd_d = W_FILL;
            gap_d = gap_inc[7:0];
          end
        end
      end
      ST_EOP: begin
        txd_d   = {crc_q, 8'h00, 8'hFD};
        pkt_d   = pkt_q + 16'd1;
        state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        ready = 1'b1;
        if (s_tvalid && s_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= ST_IDLE;
      crc_q   <= 16'hFFFF;
      wcnt_q  <= '0;
      gap_q   <= '0;
      txd_q   <= W_IDLE;
      txk_q   <= 4'b0001;
      pkt_q   <= '0;
      abort_q <= '0;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
      wcnt_q  <= wcnt_d;
      gap_q   <= gap_d;
      txd_q   <= txd_d;
      txk_q   <= txk_d;
      pkt_q   <= pkt_d;
      abort_q <= abort_d;
    end
  end

  // Gated by reset so upstream sees no handshake before the state register settles.
  assign s_tready    = ready && !areset;
  assign tx_data     = txd_q;
  assign tx_charisk  = txk_q;
  assign pkt_count   = pkt_q;
  assign abort_count = abort_q;

endmodule

// File: tb/tb_cell_link_tx_framer.sv
// Directed bench for cell_link_tx_framer (MAX_WORDS=4, GAP_TIMEOUT=16).
module tb_cell_link_tx_framer;

  localparam logic [31:0] W_IDLE  = 32'h505050BC;
  localparam logic [31:0] W_SOP   = 32'h000000FB;
  localparam logic [31:0] W_FILL  = 32'h0000001C;
  localparam logic [31:0] W_ABORT = 32'h000000FE;

  logic        aclk;
  logic        areset;
  logic        enable;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic [31:0] tx_data;
  logic [3:0]  tx_charisk;
  logic [15:0] pkt_count;
  logic [7:0]  abort_count;

  int n_asrt = 0;
  int n_fail = 0;

  cell_link_tx_framer #(.MAX_WORDS(4), .GAP_TIMEOUT(16)) dut (
    .aclk(aclk), .areset(areset), .enable(enable),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .tx_data(tx_data), .tx_charisk(tx_charisk),
    .pkt_count(pkt_count), .abort_count(abort_count)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Byte-wise CRC-16-CCITT (poly 0x1021), bytes taken MSB first.
  function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [31:0] w);
    logic [15:0] r;
    logic [7:0]  x;
    logic [7:0]  b;
    r = c;
    for (int k = 3; k >= 0; k--) begin
      b = w[k*8 +: 8];
      x = r[15:8] ^ b;
      x = x ^ (x >> 4);
      r = (r << 8) ^ ({8'h00, x} << 12) ^ ({8'h00, x} << 5) ^ {8'h00, x};
    end
    return r;
  endfunction

  function automatic logic [31:0] eop_w(input logic [15:0] c);
    return {c, 8'h00, 8'hFD};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic l);
    s_tvalid = v;
    s_tdata  = d;
    s_tlast  = l;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tx(input string tag, input logic [31:0] ed, input logic [3:0] ek);
    chk({tag, "_data"}, tx_data, ed);
    chk({tag, "_k"}, {28'h0, tx_charisk}, {28'h0, ek});
  endtask

  logic [31:0] w [0:5];
  logic [15:0] c;

  initial begin
    areset = 1'b1; enable = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick(); tick();
    chk("rst_ready", {31'h0, s_tready}, 32'h0);
    tx("rst_tx", W_IDLE, 4'b0001);
    chk("rst_pkt", {16'h0, pkt_count}, 32'h0);
    chk("rst_abort", {24'h0, abort_count}, 32'h0);
    areset = 1'b0; enable = 1'b1;
    tick(); tx("idle", W_IDLE, 4'b0001);

    // Basic 3-word packet
    drive(1'b1, 32'h11111111, 1'b0);
    tick(); tx("b_sop", W_SOP, 4'b0001);
    chk("b_ready", {31'h0, s_tready}, 32'h1);
    tick(); tx("b_p1", 32'h11111111, 4'b0000);
    drive(1'b1, 32'h22222222, 1'b0);
    tick(); tx("b_p2", 32'h22222222, 4'b0000);
    drive(1'b1, 32'h33333333, 1'b1);
    tick(); tx("b_p3", 32'h33333333, 4'b0000);
    chk("b_ready_eop", {31'h0, s_tready}, 32'h0);
    drive(1'b0, 32'h0, 1'b0);
    c = crc_word(crc_word(crc_word(16'hFFFF, 32'h11111111), 32'h22222222), 32'h33333333);
    tick(); tx("b_eop", eop_w(c), 4'b0001);
    chk("b_pkt", {16'h0, pkt_count}, 32'd1);
    tick(); tx("b_idle", W_IDLE, 4'b0001);

    // 5-cycle gap, enable dropped mid-packet
    drive(1'b1, 32'hA5A5A5A5, 1'b0);
    tick(); tx("g_sop", W_SOP, 4'b0001);
    tick(); tx("g_p1", 32'hA5A5A5A5, 4'b0000);
    enable = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(); tx("g_fill", W_FILL, 4'b0001);
    end
    drive(1'b1, 32'hDEADBEEF, 1'b0);
    tick(); tx("g_p2", 32'hDEADBEEF, 4'b0000);
    drive(1'b1, 32'h01234567, 1'b1);
    tick(); tx("g_p3", 32'h01234567, 4'b0000);
    drive(1'b0, 32'h0, 1'b0);
    c = crc_word(crc_word(crc_word(16'hFFFF, 32'hA5A5A5A5), 32'hDEADBEEF), 32'h01234567);
    tick(); tx("g_eop", eop_w(c), 4'b0001);
    chk("g_pkt", {16'h0, pkt_count}, 32'd2);
    chk("g_abort", {24'h0, abort_count}, 32'd0);
    enable = 1'b1;
    tick(); tx("g_idle", W_IDLE, 4'b0001);

    // Gap timeout: 16 empty cycles
    drive(1'b1, 32'h0000D00D, 1'b0);
    tick(); tx("t_sop", W_SOP, 4'b0001);
    tick(); tx("t_p1", 32'h0000D00D, 4'b0000);
    drive(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 15; i++) begin
      tick(); tx("t_fill", W_FILL, 4'b0001);
    end
    tick(); tx("t_abort", W_ABORT, 4'b0001);
    chk("t_abort_cnt", {24'h0, abort_count}, 32'd1);
    chk("t_ready_drain", {31'h0, s_tready}, 32'h1);
    drive(1'b1, 32'hEEEEEEEE, 1'b0);
    tick(); tx("t_drain1", W_IDLE, 4'b0001);
    drive(1'b1, 32'hFFFFFFFF, 1'b1);
    tick(); tx("t_drain2", W_IDLE, 4'b0001);
    chk("t_ready_idle", {31'h0, s_tready}, 32'h0);
    drive(1'b0, 32'h0, 1'b0);
    tick(); tx("t_idle", W_IDLE, 4'b0001);
    chk("t_pkt", {16'h0, pkt_count}, 32'd2);

    // Back-to-back single-word packets
    drive(1'b1, 32'hCAFEF00D, 1'b1);
    tick(); tx("bb_sop1", W_SOP, 4'b0001);
    tick(); tx("bb_p1", 32'hCAFEF00D, 4'b0000);
    drive(1'b1, 32'h87654321, 1'b1);
    tick(); tx("bb_eop1", eop_w(crc_word(16'hFFFF, 32'hCAFEF00D)), 4'b0001);
    chk("bb_pkt1", {16'h0, pkt_count}, 32'd3);
    tick(); tx("bb_sop2", W_SOP, 4'b0001);
    tick(); tx("bb_p2", 32'h87654321, 4'b0000);
    drive(1'b0, 32'h0, 1'b0);
    tick(); tx("bb_eop2", eop_w(crc_word(16'hFFFF, 32'h87654321)), 4'b0001);
    chk("bb_pkt2", {16'h0, pkt_count}, 32'd4);

    // Length limit: 6 words with MAX_WORDS=4
    for (int i = 0; i < 6; i++) w[i] = 32'hA0000001 + i;
    drive(1'b1, w[0], 1'b0);
    tick(); tx("l_sop", W_SOP, 4'b0001);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, w[i], 1'b0);
      tick(); tx("l_p", w[i], 4'b0000);
    end
    chk("l_ready_full", {31'h0, s_tready}, 32'h0);
    drive(1'b1, w[4], 1'b0);
    tick(); tx("l_abort", W_ABORT, 4'b0001);
    chk("l_abort_cnt", {24'h0, abort_count}, 32'd2);
    chk("l_ready_drain", {31'h0, s_tready}, 32'h1);
    tick(); tx("l_drain1", W_IDLE, 4'b0001);
    drive(1'b1, w[5], 1'b1);
    tick(); tx("l_drain2", W_IDLE, 4'b0001);
    drive(1'b0, 32'h0, 1'b0);
    tick(); tx("l_idle", W_IDLE, 4'b0001);
    chk("l_pkt", {16'h0, pkt_count}, 32'd4);

    // tlast exactly on word MAX_WORDS
    drive(1'b1, w[0], 1'b0);
    tick(); tx("m_sop", W_SOP, 4'b0001);
    c = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, w[i], (i == 3) ? 1'b1 : 1'b0);
      tick(); tx("m_p", w[i], 4'b0000);
      c = crc_word(c, w[i]);
    end
    drive(1'b0, 32'h0, 1'b0);
    tick(); tx("m_eop", eop_w(c), 4'b0001);
    chk("m_pkt", {16'h0, pkt_count}, 32'd5);
    chk("m_abort", {24'h0, abort_count}, 32'd2);

    // enable low blocks a new packet
    enable = 1'b0;
    drive(1'b1, 32'h55555555, 1'b1);
    tick(); tx("e_idle1", W_IDLE, 4'b0001);
    chk("e_ready1", {31'h0, s_tready}, 32'h0);
    tick(); tx("e_idle2", W_IDLE, 4'b0001);
    chk("e_ready2", {31'h0, s_tready}, 32'h0);

    // Reset during word 2
    enable = 1'b1;
    drive(1'b1, 32'h10101010, 1'b0);
    tick(); tx("r_sop", W_SOP, 4'b0001);
    tick(); tx("r_p1", 32'h10101010, 4'b0000);
    drive(1'b1, 32'h20202020, 1'b0);
    areset = 1'b1;
    tick(); tx("r_idle", W_IDLE, 4'b0001);
    chk("r_ready", {31'h0, s_tready}, 32'h0);
    chk("r_pkt", {16'h0, pkt_count}, 32'd0);
    chk("r_abort", {24'h0, abort_count}, 32'd0);
    areset = 1'b0;
    drive(1'b1, 32'h30303030, 1'b1);
    tick(); tx("r2_sop", W_SOP, 4'b0001);
    tick(); tx("r2_p1", 32'h30303030, 4'b0000);
    drive(1'b0, 32'h0, 1'b0);
    tick(); tx("r2_eop", eop_w(crc_word(16'hFFFF, 32'h30303030)), 4'b0001);
    chk("r2_pkt", {16'h0, pkt_count}, 32'd1);
    tick(); tx("r2_idle", W_IDLE, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
